// File: rtl/spi_seq_pkg.sv
// Shared types and sizing for the SPI transfer sequencer.
package spi_seq_pkg;

  localparam int unsigned MAX_W  = 32;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned NUM_SS = 4;
  localparam int unsigned LEN_W  = 5;
  // Edge counter must reach 2*MAX_W.
  localparam int unsigned EDGE_W = LEN_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_t;

endpackage

// File: rtl/spi_master_seq_if.sv
// Command / config / response bus between the register block and the sequencer.
interface spi_master_seq_if
  import spi_seq_pkg::*;
#(
  parameter int unsigned NUM_SS = spi_seq_pkg::NUM_SS,
  parameter int unsigned MAX_W  = spi_seq_pkg::MAX_W,
  parameter int unsigned DIV_W  = spi_seq_pkg::DIV_W
);

  localparam int unsigned SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [SS_W-1:0]  cmd_ss;
  logic [LEN_W-1:0] cmd_len;
  logic [MAX_W-1:0] cmd_data;
  logic             cfg_cpol;
  logic             cfg_cpha;
  logic [DIV_W-1:0] cfg_div;
  logic             rsp_valid;
  logic [MAX_W-1:0] rsp_data;
  logic             busy;

  modport master (
    output cmd_valid, cmd_ss, cmd_len, cmd_data, cfg_cpol, cfg_cpha, cfg_div,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_ss, cmd_len, cmd_data, cfg_cpol, cfg_cpha, cfg_div,
    output cmd_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/spi_hp_tick.sv
// Half-period down-counter: ticks at zero and reloads the divider value.
module spi_hp_tick #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  assign tick_c = (cnt == '0);

  // Reload on an explicit load or on tick, otherwise count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load || tick_c) begin
      cnt <= div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_seq.sv
// SPI master transfer sequencer: one command at a time, CPOL/CPHA modes 0-3,
// 1..32-bit MSB-first transfers, programmable SCLK half-period.
module spi_master_seq
  import spi_seq_pkg::*;
#(
  parameter int unsigned NUM_SS = spi_seq_pkg::NUM_SS,
  parameter int unsigned MAX_W  = spi_seq_pkg::MAX_W,
  parameter int unsigned DIV_W  = spi_seq_pkg::DIV_W
) (
  input  logic              pclk,
  input  logic              n_p_reset,
  spi_master_seq_if.slave   bus,
  output logic              n_ss_en,
  output logic [NUM_SS-1:0] n_ss_out,
  output logic              n_sclk_en,
  output logic              sclk_out,
  output logic              n_mo_en,
  output logic              mo,
  input  logic              mi
);

  state_t            state;
  logic              cpol_q;
  logic              cpha_q;
  logic [LEN_W-1:0]  len_q;
  logic [DIV_W-1:0]  div_q;
  logic [MAX_W-1:0]  tx;
  logic [MAX_W-1:0]  rx;
  logic [EDGE_W-1:0] edge_cnt;
  logic              rsp_valid_q;
  logic [MAX_W-1:0]  rsp_data_q;

  logic              accept_c;
  logic              tick_c;
  logic [DIV_W-1:0]  hp_div_c;
  logic [MAX_W-1:0]  tx_load_c;
  logic [MAX_W-1:0]  rsp_mask_c;
  logic [EDGE_W-1:0] last_edge_c;
  logic [EDGE_W-1:0] shift_done_c;
  logic              leading_c;
  logic              sample_c;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  assign accept_c     = bus.cmd_valid && (state == IDLE);
  assign hp_div_c     = accept_c ? bus.cfg_div : div_q;
  assign tx_load_c    = bus.cmd_data << (LEN_W'(MAX_W - 1) - bus.cmd_len);
  assign rsp_mask_c   = {MAX_W{1'b1}} >> (LEN_W'(MAX_W - 1) - len_q);
  assign last_edge_c  = {1'b0, len_q, 1'b1};
  assign shift_done_c = last_edge_c + EDGE_W'(1);
  // Even edge indices are leading edges; CPHA selects which type samples.
  assign leading_c    = ~edge_cnt[0];
  assign sample_c     = leading_c ^ cpha_q;

  spi_hp_tick #(
    .DIV_W (DIV_W)
  ) u_hp_tick (
    .clk    (pclk),
    .rst_n  (n_p_reset),
    .load   (accept_c),
    .div    (hp_div_c),
    .tick_c (tick_c)
  );

  // Transfer FSM with registered pad outputs and response.
  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      state       <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      len_q       <= '0;
      div_q       <= '0;
      tx          <= '0;
      rx          <= '0;
      edge_cnt    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      n_ss_en     <= 1'b1;
      n_ss_out    <= '1;
      n_sclk_en   <= 1'b1;
      sclk_out    <= 1'b0;
      n_mo_en     <= 1'b1;
      mo          <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          sclk_out <= bus.cfg_cpol;
          if (accept_c) begin
            state     <= SETUP;
            cpol_q    <= bus.cfg_cpol;
            cpha_q    <= bus.cfg_cpha;
            len_q     <= bus.cmd_len;
            div_q     <= bus.cfg_div;
            tx        <= tx_load_c;
            rx        <= '0;
            edge_cnt  <= '0;
            n_ss_out  <= ~(NUM_SS'(1) << bus.cmd_ss);
            n_ss_en   <= 1'b0;
            n_sclk_en <= 1'b0;
            n_mo_en   <= 1'b0;
            // CPHA0 presents the first bit before the first edge.
            mo        <= bus.cfg_cpha ? 1'b0 : tx_load_c[MAX_W-1];
          end
        end
        SETUP, SHIFT: begin
          if (tick_c) begin
            if ((state == SHIFT) && (edge_cnt == shift_done_c)) begin
              state     <= GAP;
              sclk_out  <= cpol_q;
              n_ss_out  <= '1;
              n_ss_en   <= 1'b1;
              n_sclk_en <= 1'b1;
              n_mo_en   <= 1'b1;
              mo        <= 1'b0;
            end else begin
              state    <= SHIFT;
              sclk_out <= ~sclk_out;
              edge_cnt <= edge_cnt + EDGE_W'(1);
              if (sample_c) begin
                rx <= {rx[MAX_W-2:0], mi};
              end
              if (leading_c && cpha_q) begin
                mo <= tx[MAX_W-1];
                tx <= tx << 1;
              end else if (!leading_c && !cpha_q && (edge_cnt != last_edge_c)) begin
                mo <= tx[MAX_W-2];
                tx <= tx << 1;
              end
            end
          end
        end
        GAP: begin
          if (tick_c) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx & rsp_mask_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_seq.sv
// Self-checking bench for spi_master_seq: vector table, random transfers
// against an SPI slave model, back-to-back and reset-abort sequences.
module tb_spi_master_seq;

  localparam int unsigned NSS = 4;
  localparam int unsigned DW  = 32;

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [1:0]  ss;
    logic [4:0]  len;
    logic [7:0]  div;
    logic [31:0] data;
    logic        loop;
    logic [31:0] slv;
    logic [31:0] exp_rsp;
    logic [31:0] exp_slv;
    logic [3:0]  exp_ss;
    int          exp_lat;
    int          exp_first;
    int          exp_tog;
  } vec_t;

  logic           pclk = 1'b0;
  logic           n_p_reset = 1'b1;
  logic           n_ss_en;
  logic [NSS-1:0] n_ss_out;
  logic           n_sclk_en;
  logic           sclk_out;
  logic           n_mo_en;
  logic           mo;
  logic           mi;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // Slave model and pin monitor state
  logic        loopback  = 1'b1;
  logic [31:0] slv_tx    = '0;
  logic [31:0] slv_sr    = '0;
  logic [31:0] slv_rx    = '0;
  logic        slv_mi    = 1'b0;
  int          slv_edges = 0;
  logic        cur_cpha  = 1'b0;
  logic [4:0]  cur_len   = '0;
  int          toggles   = 0;
  int          first_tog = -1;
  logic [3:0]  ss_seen   = 4'hF;
  logic        prev_sclk = 1'b0;
  logic [3:0]  prev_ss   = 4'hF;

  spi_master_seq_if #(.NUM_SS(NSS), .MAX_W(DW), .DIV_W(8)) bus ();

  spi_master_seq #(.NUM_SS(NSS), .MAX_W(DW), .DIV_W(8)) dut (
    .pclk      (pclk),
    .n_p_reset (n_p_reset),
    .bus       (bus),
    .n_ss_en   (n_ss_en),
    .n_ss_out  (n_ss_out),
    .n_sclk_en (n_sclk_en),
    .sclk_out  (sclk_out),
    .n_mo_en   (n_mo_en),
    .mo        (mo),
    .mi        (mi)
  );

  assign mi = loopback ? mo : slv_mi;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // SPI slave: shifts slv_tx out on its drive edges, captures mo on sample edges.
  always @(negedge pclk) begin
    if (n_ss_out != 4'hF) ss_seen = n_ss_out;
    if (!n_sclk_en && (sclk_out != prev_sclk)) begin
      toggles++;
      if (first_tog < 0) first_tog = cyc;
    end
    if ((n_ss_out != 4'hF) && (prev_ss == 4'hF)) begin
      slv_sr    = slv_tx << (31 - int'(cur_len));
      slv_rx    = '0;
      slv_edges = 0;
      slv_mi    = cur_cpha ? 1'b0 : slv_sr[31];
    end else if ((n_ss_out != 4'hF) && (sclk_out != prev_sclk)) begin
      if (((slv_edges % 2) == 0) != cur_cpha) begin
        slv_rx = {slv_rx[30:0], mo};
      end else if (cur_cpha) begin
        slv_mi = slv_sr[31];
        slv_sr = slv_sr << 1;
      end else begin
        slv_sr = slv_sr << 1;
        slv_mi = slv_sr[31];
      end
      slv_edges++;
    end
    prev_sclk = sclk_out;
    prev_ss   = n_ss_out;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lenmask(input logic [4:0] len);
    return 32'((64'd1 << (len + 6'd1)) - 64'd1);
  endfunction

  // Bounded wait for rsp_valid, sampled 1 time unit after each rising edge.
  task automatic wait_rsp(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge pclk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int t0;
    bit got;
    @(posedge pclk); #1;
    bus.cfg_cpol = v.cpol;
    bus.cfg_cpha = v.cpha;
    bus.cfg_div  = v.div;
    loopback     = v.loop;
    slv_tx       = v.slv;
    cur_cpha     = v.cpha;
    cur_len      = v.len;
    @(posedge pclk); #1;
    chk({tag, "_idle_sclk"}, 64'(sclk_out), 64'(v.cpol));
    chk({tag, "_ready"}, 64'(bus.cmd_ready), 64'(1'b1));
    bus.cmd_ss    = v.ss;
    bus.cmd_len   = v.len;
    bus.cmd_data  = v.data;
    bus.cmd_valid = 1'b1;
    toggles   = 0;
    first_tog = -1;
    ss_seen   = 4'hF;
    t0        = cyc;
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    chk({tag, "_busy"}, 64'(bus.busy), 64'(1'b1));
    wait_rsp(20000, got);
    chk({tag, "_rsp_seen"}, 64'(got), 64'(1'b1));
    chk({tag, "_latency"}, 64'(cyc - t0), 64'(v.exp_lat));
    chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(v.exp_rsp));
    chk({tag, "_toggles"}, 64'(toggles), 64'(v.exp_tog));
    chk({tag, "_first_edge"}, 64'(first_tog - t0), 64'(v.exp_first));
    chk({tag, "_n_ss"}, 64'(ss_seen), 64'(v.exp_ss));
    chk({tag, "_slave_rx"}, 64'(slv_rx), 64'(v.exp_slv));
    chk({tag, "_end_sclk"}, 64'(sclk_out), 64'(v.cpol));
    chk({tag, "_end_pins"}, 64'({n_ss_en, n_sclk_en, n_mo_en, n_ss_out}), 64'(7'h7F));
    @(posedge pclk); #1;
    chk({tag, "_rsp_pulse"}, 64'(bus.rsp_valid), 64'(1'b0));
  endtask

  vec_t tbl[6];
  vec_t r;
  int   n;
  int   t0;
  bit   got;
  bit   seen;

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            cpol  cpha  ss    len    div     data           loop  slv           exp_rsp        exp_slv        exp_ss    lat    1st  tog
    tbl[0] = '{1'b0, 1'b0, 2'd2, 5'd7,  8'd0,   32'h000000A5, 1'b1, 32'h0,        32'h000000A5, 32'h000000A5, 4'b1011, 19,    2,   16};
    tbl[1] = '{1'b0, 1'b1, 2'd0, 5'd15, 8'd3,   32'h00001234, 1'b0, 32'h0000BEEF, 32'h0000BEEF, 32'h00001234, 4'b1110, 137,   5,   32};
    tbl[2] = '{1'b1, 1'b0, 2'd1, 5'd15, 8'd3,   32'h00001234, 1'b0, 32'h0000BEEF, 32'h0000BEEF, 32'h00001234, 4'b1101, 137,   5,   32};
    tbl[3] = '{1'b1, 1'b1, 2'd3, 5'd15, 8'd3,   32'h00001234, 1'b0, 32'h0000BEEF, 32'h0000BEEF, 32'h00001234, 4'b0111, 137,   5,   32};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 5'd0,  8'd0,   32'h00000001, 1'b0, 32'h0,        32'h00000000, 32'h00000001, 4'b1110, 5,     2,   2};
    tbl[5] = '{1'b0, 1'b0, 2'd1, 5'd31, 8'd255, 32'hDEADBEEF, 1'b1, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 4'b1101, 16897, 257, 64};

    bus.cmd_valid = 1'b0;
    bus.cmd_ss    = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.cfg_cpol  = 1'b0;
    bus.cfg_cpha  = 1'b0;
    bus.cfg_div   = '0;

    // Reset values
    #2 n_p_reset = 1'b0;
    #1;
    chk("reset_n_ss_out", 64'(n_ss_out), 64'(4'hF));
    chk("reset_enables", 64'({n_ss_en, n_sclk_en, n_mo_en}), 64'(3'b111));
    chk("reset_sclk_mo", 64'({sclk_out, mo}), 64'(2'b00));
    chk("reset_rsp", 64'({bus.rsp_valid, bus.rsp_data}), 64'(0));
    chk("reset_busy_ready", 64'({bus.busy, bus.cmd_ready}), 64'(2'b01));
    #20 n_p_reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Random transfers checked against length/divider arithmetic
    for (int k = 0; k < 16; k++) begin
      r.cpol      = 1'($urandom);
      r.cpha      = 1'($urandom);
      r.ss        = 2'($urandom);
      r.len       = 5'($urandom);
      r.div       = 8'($urandom_range(0, 3));
      r.data      = $urandom;
      r.loop      = 1'b0;
      r.slv       = $urandom;
      r.exp_rsp   = r.slv & lenmask(r.len);
      r.exp_slv   = r.data & lenmask(r.len);
      r.exp_ss    = ~(4'b0001 << r.ss);
      n           = int'(r.len) + 1;
      r.exp_lat   = 1 + (2 * n + 2) * (int'(r.div) + 1);
      r.exp_first = 2 + int'(r.div);
      r.exp_tog   = 2 * n;
      run_vec(r, $sformatf("rand%0d", k));
    end

    // Back-to-back: second command accepted in the rsp_valid cycle
    @(posedge pclk); #1;
    bus.cfg_cpol = 1'b0;
    bus.cfg_cpha = 1'b0;
    bus.cfg_div  = 8'd1;
    loopback     = 1'b1;
    cur_cpha     = 1'b0;
    cur_len      = 5'd3;
    bus.cmd_ss   = 2'd0;
    bus.cmd_len  = 5'd3;
    bus.cmd_data = 32'h9;
    bus.cmd_valid = 1'b1;
    t0 = cyc;
    @(posedge pclk); #1;
    bus.cmd_len  = 5'd5;
    bus.cmd_data = 32'h25;
    bus.cfg_div  = 8'd2;
    cur_len      = 5'd5;
    wait_rsp(500, got);
    chk("b2b_rsp1_seen", 64'(got), 64'(1'b1));
    chk("b2b_lat1", 64'(cyc - t0), 64'(21));
    chk("b2b_rsp1_data", 64'(bus.rsp_data), 64'(32'h9));
    chk("b2b_ready_in_rsp", 64'({bus.cmd_ready, bus.busy}), 64'(2'b10));
    t0 = cyc;
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    chk("b2b_second_accept", 64'(bus.busy), 64'(1'b1));
    wait_rsp(500, got);
    chk("b2b_rsp2_seen", 64'(got), 64'(1'b1));
    chk("b2b_lat2", 64'(cyc - t0), 64'(43));
    chk("b2b_rsp2_data", 64'(bus.rsp_data), 64'(32'h25));

    // Reset during SHIFT aborts the transfer
    @(posedge pclk); #1;
    bus.cfg_div   = 8'd2;
    bus.cmd_len   = 5'd7;
    bus.cmd_data  = 32'hF0;
    bus.cmd_valid = 1'b1;
    toggles = 0;
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (toggles >= 3) begin
        got = 1'b1;
        break;
      end
      @(posedge pclk); #1;
    end
    chk("rst_reached_shift", 64'(got), 64'(1'b1));
    #2 n_p_reset = 1'b0;
    #1;
    chk("rst_n_ss_out", 64'(n_ss_out), 64'(4'hF));
    chk("rst_enables", 64'({n_ss_en, n_sclk_en, n_mo_en}), 64'(3'b111));
    chk("rst_sclk", 64'(sclk_out), 64'(1'b0));
    chk("rst_busy", 64'({bus.busy, bus.rsp_valid}), 64'(2'b00));
    seen = 1'b0;
    repeat (3) begin
      @(posedge pclk); #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    n_p_reset = 1'b1;
    repeat (60) begin
      @(posedge pclk); #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rst_no_rsp", 64'(seen), 64'(1'b0));
    run_vec(tbl[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
- Transfer sequencer for the SPI master pins: accepts one command at a time and generates slave select, SCLK and MOSI.
- Samples MISO and returns the received word.
- Sits between the APB register block (command/config source) and the SPI master pad signals.
- Supports CPOL/CPHA modes 0-3, 1..32-bit transfers (MSB first) and a programmable SCLK divider.

Parameters:
- NUM_SS, 4, number of slave selects; SS_W = $clog2(NUM_SS).
- MAX_W, 32, maximum transfer width and width of the data registers.
- DIV_W, 8, width of the divider field.

Ports:
- pclk  in  1  system clock
- n_p_reset  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  = (state==IDLE); command is accepted when valid&&ready
- cmd_ss  in  SS_W  slave index
- cmd_len  in  5  bits minus 1 (0 gives 1 bit, 31 gives 32 bits)
- cmd_data  in  MAX_W  TX data, right-aligned
- cfg_cpol  in  1  idle SCLK level
- cfg_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- cfg_div  in  DIV_W  half-period = cfg_div+1 pclk cycles
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid in that cycle
- rsp_data  out  MAX_W  RX data, right-aligned, upper bits zero
- busy  out  1  = (state!=IDLE)
- n_ss_en  out  1  active-low pad enable for slave select
- n_ss_out  out  NUM_SS  active-low slave selects
- n_sclk_en  out  1  active-low SCLK pad enable
- sclk_out  out  1  SCLK
- n_mo_en  out  1  active-low MOSI pad enable
- mo  out  1  MOSI
- mi  in  1  MISO

Behaviour:
- Reset values (asynchronous, n_p_reset=0): state IDLE; n_ss_out all 1s; n_ss_en=1; n_sclk_en=1; n_mo_en=1; sclk_out=0; mo=0; rsp_valid=0; rsp_data=0; busy=0. cmd_ready=1.
- Reset mid-transfer aborts the transfer: no rsp_valid pulse, pins return to reset values immediately.
- All outputs except cmd_ready and busy are registered.
- On accept:
  - cmd_ss, cmd_len, cpol, cpha and div are latched; later cfg changes are ignored until the next accept.
  - TX shift register loads cmd_data << (31-cmd_len), so mo is always tx[31].
  - N = cmd_len+1.
- Half-period counter loads div and decrements; "tick" occurs when it is 0 and it reloads on tick.
- States:
  - IDLE: sclk_out <= cfg_cpol each cycle. Accept moves to SETUP.
  - SETUP (1 half-period):
    - n_ss_out[ss]=0, n_ss_en=0, n_sclk_en=0, n_mo_en=0.
    - CPHA0: mo = first bit from the first SETUP cycle.
    - tick moves to SHIFT.
  - SHIFT (2N half-periods): sclk_out toggles in the first cycle of each half-period, giving 2N edges, odd-numbered edges leading.
    - Sample edges capture the mi value present in the cycle before the toggle, shifting it into the rx LSB (rx <= {rx[30:0],mi}).
    - Sample edges are leading for CPHA0 and trailing for CPHA1.
    - Drive edges are the other edge type:
      - CPHA1: each leading edge drives the next bit onto mo.
      - CPHA0: each trailing edge except the last advances tx.
    - Edge counter 0..2N-1. Tick at the end of the 2N-th half-period moves to GAP.
  - GAP (1 half-period): sclk_out=cpol; all n_ss_out=1; enables=1; mo=0. Tick moves to IDLE, with rsp_valid=1 and rsp_data = rx masked to N bits in the IDLE entry cycle.
- Latency: accept at cycle T gives rsp_valid at T+1+(2N+2)*(div+1).
- A back-to-back command may be accepted in the rsp_valid cycle. rsp_valid is not back-pressured.
- div=0: every cycle is a tick; all rules still hold.
- N=1: 2 edges, rsp_data[0] only.

Decomposition:
- Package spi_seq_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, GAP)
  - MAX_W and DIV_W defaults
  - constant LEN_W=5
- One natural sub-module: spi_hp_tick (half-period down-counter with load and tick output).
- Shift registers, edge counter and FSM stay in spi_master_seq.

Test Plan:
- Mode 0, div=0, ss=2, len=7, data=0xA5, mi looped from mo, accept at T:
  - n_ss_out=4'b1011 during transfer;
  - 16 sclk toggles, first at T+2;
  - rsp_valid at T+19 with rsp_data=0x000000A5.
- Modes 1/2/3, div=3, len=15, data=0x1234, mi driven by a slave model shifting 0xBEEF on the opposite edge -> rsp_data=0xBEEF; sclk idles at cpol; rsp_valid at T+1+34*4 = T+137.
- len=0, data=1, mi=0 -> exactly 2 sclk edges, mo=1 during SHIFT, rsp_data=0.
- len=31, data=0xDEADBEEF, loopback, div=255 -> rsp_data=0xDEADBEEF at T+1+66*256.
- Hold cmd_valid high with two queued commands -> second accepted in the rsp_valid cycle; one-cycle IDLE between transfers; cfg_div change mid-transfer has no effect on the current transfer's timing.
- Assert n_p_reset=0 during SHIFT -> same cycle: all n_ss_out=1, enables=1, sclk_out=0, no rsp_valid; after release, a new command completes normally.
